// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; the entry type is also consumed by decode.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer with flush; the head entry is held in output registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DW    = 2 * XLEN,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] mem_n_s [DEPTH];
    logic [AW-1:0] wr_r, rd_r, wr_n_s, rd_n_s;
    logic [CW-1:0] cnt_r, cnt_n_s;
    logic [DW-1:0] head_r;
    logic          valid_r;

    // Next-state storage and pointers; pointers wrap naturally modulo DEPTH.
    always_comb begin
        mem_n_s = mem_r;
        wr_n_s  = wr_r;
        rd_n_s  = rd_r;
        cnt_n_s = cnt_r;
        if (flush) begin
            wr_n_s  = {AW{1'b0}};
            rd_n_s  = {AW{1'b0}};
            cnt_n_s = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_n_s[wr_r] = push_data;
                wr_n_s        = wr_r + AW'(1'b1);
            end else begin
                wr_n_s = wr_r;
            end
            if (pop) begin
                rd_n_s = rd_r + AW'(1'b1);
            end else begin
                rd_n_s = rd_r;
            end
            cnt_n_s = cnt_r + CW'(push) - CW'(pop);
        end
    end

    // State update; the head registers preload the entry that will be at the head next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_r    <= {AW{1'b0}};
            rd_r    <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            head_r  <= {DW{1'b0}};
            valid_r <= 1'b0;
        end else begin
            mem_r   <= mem_n_s;
            wr_r    <= wr_n_s;
            rd_r    <= rd_n_s;
            cnt_r   <= cnt_n_s;
            head_r  <= mem_n_s[rd_n_s];
            valid_r <= (cnt_n_s != {CW{1'b0}});
        end
    end

    assign head_valid = valid_r;
    assign head_data  = head_r;
    assign count      = cnt_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited requests to imem, discard of
// stale responses after a redirect, and a small buffer feeding decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0]   fetch_pc_r;
    logic [WIDTH-1:0]   resp_pc_r;
    logic [WIDTH-1:0]   target_s;
    logic [CW-1:0]      outst_r, disc_r, cnt_s, outst_next_s;
    logic               credit_s, grant_s, drop_s, push_s, pop_s;
    logic [2*WIDTH-1:0] head_s;
    logic               unused_pc_bits_s;

    // Credit check and per-cycle handshake decode; everything feeding imem_req is registered.
    always_comb begin
        credit_s     = ({1'b0, cnt_s} + {1'b0, outst_r}) < CREDITS;
        grant_s      = imem_req & imem_gnt;
        drop_s       = redirect | (disc_r != {CW{1'b0}});
        push_s       = imem_rvalid & ~drop_s;
        pop_s        = instr_valid & instr_ready;
        outst_next_s = outst_r + CW'(grant_s) - CW'(imem_rvalid);
        target_s     = {redirect_pc[WIDTH-1:2], 2'b00};
    end

    assign imem_req         = credit_s & ~rst;
    assign imem_addr        = fetch_pc_r;
    assign unused_pc_bits_s = ^redirect_pc[1:0];

    // resp_pc_r tracks the PC of the next response that will be kept, so discarded
    // words never advance it and it restarts at the target on a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            outst_r    <= {CW{1'b0}};
            disc_r     <= {CW{1'b0}};
        end else begin
            outst_r <= outst_next_s;
            if (redirect) begin
                fetch_pc_r <= target_s;
                resp_pc_r  <= target_s;
                disc_r     <= outst_next_s;
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + WIDTH'(INSTR_BYTES);
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + WIDTH'(INSTR_BYTES);
                end
                if (imem_rvalid && (disc_r != {CW{1'b0}})) begin
                    disc_r <= disc_r - CW'(1'b1);
                end
            end
        end
    end

    fetch_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push_s),
        .push_data  ({resp_pc_r, imem_rdata}),
        .pop        (pop_s),
        .head_valid (instr_valid),
        .head_data  (head_s),
        .count      (cnt_s)
    );

    assign instr_pc = head_s[2*WIDTH-1:WIDTH];
    assign instr    = head_s[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk, rst, redirect, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_pop = 0;
    int           cyc = 0;
    int           lat = 1;
    logic [31:0]  exp_pc, first_tgt, s_addr;
    logic         want_first, s_req, s_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_5A5A) + 32'h0000_0013;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs, model memory, update scoreboard, drive inputs.
    task automatic run_cycle(input logic rdy, input logic g, input logic rd, input logic [31:0] tgt);
        mreq_t        m;
        fetch_entry_t e;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        if (s_req) check_value("req_addr", 64'(s_addr), 64'(exp_pc));
        instr_ready = rdy;
        if (s_valid && rdy) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check_value("sb_size", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_value("pop_pc", 64'(instr_pc), 64'(e.pc));
                check_value("pop_instr", 64'(instr), 64'(e.instr));
                if (want_first) check_value("first_pc", 64'(instr_pc), 64'(first_tgt));
                want_first = 1'b0;
            end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m           = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m.addr);
        end
        imem_gnt = g;
        if (g && s_req) begin
            m.addr  = s_addr;
            m.due   = cyc + lat;
            mq.push_back(m);
            e.pc    = s_addr;
            e.instr = mem_word(s_addr);
            exp_q.push_back(e);
        end
        redirect    = rd;
        redirect_pc = tgt;
        if (rd) begin
            exp_q.delete();
            exp_pc     = {tgt[31:2], 2'b00};
            first_tgt  = {tgt[31:2], 2'b00};
            want_first = 1'b1;
        end else if (g && s_req) begin
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        #1;
        check_value("rst_req", 64'(imem_req), 64'd0);
        check_value("rst_valid", 64'(instr_valid), 64'd0);
        check_value("rst_instr", 64'(instr), 64'd0);
        check_value("rst_pc", 64'(instr_pc), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        exp_pc     = 32'h0;
        cyc        = 0;
        want_first = 1'b0;
    endtask

    // Stop granting and let every expected word come out, then confirm nothing extra appears.
    task automatic drain();
        for (int k = 0; k < 40 && (exp_q.size() > 0 || mq.size() > 0); k++) begin
            run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        end
        check_value("drain_empty", 64'(exp_q.size()), 64'd0);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_value("no_extra", 64'(s_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int p0;

        // Streaming with 1-cycle latency
        do_reset();
        lat   = 1;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (k == 0) check_value("req_after_rst", 64'(s_req), 64'd1);
            if (s_valid && first < 0) first = k;
        end
        check_value("first_valid_cycle", 64'(first), 64'd2);
        drain();

        // Decode stall: buffer fills, requests stop
        do_reset();
        lat = 1;
        for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_value("stall_req", 64'(s_req), 64'd0);
        check_value("stall_valid", 64'(s_valid), 64'd1);
        check_value("stall_grants", 64'(exp_q.size()), 64'd2);
        check_value("stall_outst", 64'(mq.size()), 64'd0);
        p0 = n_pop;
        drain();
        check_value("stall_pops", 64'(n_pop - p0), 64'd2);

        // Redirect with two requests in flight, latency 3
        do_reset();
        lat = 3;
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        check_value("inflight_req", 64'(s_req), 64'd0);
        for (int k = 0; k < 10; k++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Redirect coinciding with a response and a grant
        do_reset();
        lat = 1;
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check_value("coinc_req", 64'(s_req), 64'd1);
        for (int k = 0; k < 8; k++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Unaligned target, full buffer flushed with a same-cycle pop
        for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_value("full_valid", 64'(s_valid), 64'd1);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_value("align_req", 64'(s_req), 64'd1);
        check_value("align_addr", 64'(s_addr), 64'h100);
        for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Address wrap at the top of the address space
        run_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_value("top_addr", 64'(s_addr), 64'hFFFF_FFFC);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_value("wrap_addr", 64'(s_addr), 64'h0);
        drain();

        // Asynchronous reset with a full buffer
        do_reset();
        lat = 1;
        for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_value("full_before_rst", 64'(s_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_value("async_valid", 64'(instr_valid), 64'd0);
        check_value("async_instr", 64'(instr), 64'd0);
        check_value("async_pc", 64'(instr_pc), 64'd0);
        check_value("async_req", 64'(imem_req), 64'd0);
        do_reset();
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_value("restart_req", 64'(s_req), 64'd1);
        check_value("restart_addr", 64'(s_addr), 64'h0);
        for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
